// File: rtl/mul_div.sv
// Iterative multiply/divide unit: one bit per cycle over WIDTH cycles, signed ops via
// magnitude arithmetic with a final sign-fix cycle.
module mul_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CW-1:0]      iter;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   dividend_r;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   shreg;
    logic               a_neg;
    logic               b_neg;

    logic               in_a_neg;
    logic               in_b_neg;
    logic [WIDTH-1:0]   in_a_mag;
    logic [WIDTH-1:0]   in_b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand magnitudes; unsigned ops never count as negative.
    always_comb begin
        in_a_neg = op[0] & op1[WIDTH-1];
        in_b_neg = op[0] & op2[WIDTH-1];
        in_a_mag = in_a_neg ? -op1 : op1;
        in_b_mag = in_b_neg ? -op2 : op2;
    end

    // One iteration of shift-add multiply and restoring divide.
    // The multiplier (or dividend) shifts through shreg; acc holds the upper product half
    // (or the partial remainder).
    always_comb begin
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, divisor_mag} : {(WIDTH + 1){1'b0}});
        div_shift = {acc, shreg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, divisor_mag});
        div_diff  = div_shift[WIDTH-1:0] - divisor_mag;
        prod_fix  = (a_neg ^ b_neg) ? -{acc, shreg} : {acc, shreg};
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: if (iter == LAST_ITER) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            iter        <= '0;
            op_r        <= '0;
            dividend_r  <= '0;
            divisor_mag <= '0;
            acc         <= '0;
            shreg       <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div0        <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r        <= op;
                        dividend_r  <= op1;
                        divisor_mag <= in_b_mag;
                        a_neg       <= in_a_neg;
                        b_neg       <= in_b_neg;
                        acc         <= '0;
                        shreg       <= in_a_mag;
                        iter        <= '0;
                    end
                end
                S_CALC: begin
                    iter <= iter + CW'(1);
                    if (op_r[1]) begin
                        acc   <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        shreg <= {shreg[WIDTH-2:0], div_ge};
                    end else begin
                        acc   <= mul_sum[WIDTH:1];
                        shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (op_r[1]) begin
                        if (divisor_mag == '0) begin
                            div0 <= 1'b1;
                            lo   <= '1;
                            hi   <= dividend_r;
                        end else begin
                            // Quotient sign from both operands, remainder follows the dividend.
                            div0 <= 1'b0;
                            lo   <= (a_neg ^ b_neg) ? -shreg : shreg;
                            hi   <= a_neg ? -acc : acc;
                        end
                    end else begin
                        div0 <= 1'b0;
                        hi   <= prod_fix[2*WIDTH-1:WIDTH];
                        lo   <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div.sv
// Self-checking bench for mul_div: directed vectors, reset abort, ignored start,
// back-to-back operation and a biased random run against an arithmetic reference model.
module tb_mul_div;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [1:0]    op;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div0;

    int tests = 0;
    int fails = 0;

    mul_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .op1   (op1),
        .op2   (op2),
        .op    (op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                p  = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    ed = 1'b1;
                    el = '1;
                    eh = a;
                end else if (o == 2'd2) begin
                    el = a / b;
                    eh = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
        endcase
    endfunction

    // Drives one request and waits for done; returns results, latency and busy observations.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rd0,
                          output int lat, output bit busy_ok, output logic busy_done);
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        rhi       = hi;
        rlo       = lo;
        rd0       = div0;
        busy_done = busy;
    endtask

    function automatic logic [W-1:0] biased();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        op1   = '0;
        op2   = '0;
        tick();
        tick();
        tests++;
        if ({busy, done, div0} !== 3'b000 || hi !== '0 || lo !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b div0=%b hi=%h lo=%h, required all 0",
                     busy, done, div0, hi, lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]   vop [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3};
        logic [W-1:0] va  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h64, 32'h8000_0000, 32'h7};
        logic [W-1:0] vb  [6] = '{32'hFFFF_FFFF, 32'h5, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [W-1:0] vh  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h64, 32'h0, 32'h7};
        logic [W-1:0] vl  [6] = '{32'h1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic         vd  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic         rd;
        logic         bd;
        int           lat;
        bit           bok;
        for (int i = 0; i < 6; i++) begin
            run_op(vop[i], va[i], vb[i], rh, rl, rd, lat, bok, bd);
            tests++;
            if (rh !== vh[i] || rl !== vl[i] || rd !== vd[i]) begin
                fails++;
                $display("FAIL directed_%0d: hi=%h lo=%h div0=%b, required hi=%h lo=%h div0=%b",
                         i, rh, rl, rd, vh[i], vl[i], vd[i]);
            end
            tests++;
            if (lat != LAT || !bok || bd !== 1'b0) begin
                fails++;
                $display("FAIL directed_timing_%0d: latency=%0d busy_ok=%0b busy_at_done=%b, required %0d 1 0",
                         i, lat, bok, bd, LAT);
            end
        end
        tick();
        tests++;
        if (done !== 1'b0 || hi !== 32'h7 || lo !== '1 || div0 !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse_hold: done=%b hi=%h lo=%h div0=%b, required 0 00000007 ffffffff 1",
                     done, hi, lo, div0);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic         rd;
        logic         bd;
        int           lat;
        bit           bok;
        int           ndone;
        op    = 2'd0;
        op1   = '1;
        op2   = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div0 !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear: busy=%b done=%b hi=%h lo=%h div0=%b, required all 0",
                     busy, done, hi, lo, div0);
        end
        ndone = 0;
        repeat (40) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", ndone);
        end
        run_op(2'd0, 32'd6, 32'd7, rh, rl, rd, lat, bok, bd);
        tests++;
        if (rh !== 32'h0 || rl !== 32'h2A || lat != LAT) begin
            fails++;
            $display("FAIL after_abort: hi=%h lo=%h latency=%0d, required 0 2a %0d", rh, rl, lat, LAT);
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        int           lat;
        int           ndone;
        model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, ed);
        op    = 2'd0;
        op1   = 32'h1234_5678;
        op2   = 32'h9ABC_DEF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        repeat (5) begin
            tick();
            lat++;
        end
        op    = 2'd3;
        op1   = 32'd99;
        op2   = 32'd3;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        op1   = W'($urandom);
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        tests++;
        if (hi !== eh || lo !== el || div0 !== ed || lat != LAT) begin
            fails++;
            $display("FAIL ignore_start: hi=%h lo=%h div0=%b latency=%0d, required %h %h %b %0d",
                     hi, lo, div0, lat, eh, el, ed, LAT);
        end
        tick();
        ndone = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            tick();
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL start_not_queued: %0d busy/done cycles after op, required 0", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic         rd;
        logic         bd;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        int           lat;
        bit           bok;
        run_op(2'd1, 32'hFFFF_FF00, 32'h0000_0123, rh, rl, rd, lat, bok, bd);
        model(2'd1, 32'hFFFF_FF00, 32'h0000_0123, eh, el, ed);
        tests++;
        if (rh !== eh || rl !== el || rd !== ed) begin
            fails++;
            $display("FAIL b2b_first: hi=%h lo=%h div0=%b, required %h %h %b", rh, rl, rd, eh, el, ed);
        end
        run_op(2'd2, 32'd1000, 32'd7, rh, rl, rd, lat, bok, bd);
        tests++;
        if (rh !== 32'd6 || rl !== 32'd142 || rd !== 1'b0 || lat != LAT) begin
            fails++;
            $display("FAIL b2b_second: hi=%h lo=%h div0=%b latency=%0d, required 6 8e 0 %0d",
                     rh, rl, rd, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic         rd;
        logic         bd;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        int           lat;
        bit           bok;
        int           nbad;
        nbad = 0;
        for (int i = 0; i < 1500; i++) begin
            o = 2'($urandom_range(0, 3));
            a = biased();
            b = biased();
            if ($urandom_range(0, 7) == 0) tick();
            run_op(o, a, b, rh, rl, rd, lat, bok, bd);
            model(o, a, b, eh, el, ed);
            tests++;
            if (rh !== eh || rl !== el || rd !== ed || lat != LAT || !bok || bd !== 1'b0) begin
                fails++;
                nbad++;
                if (nbad <= 10)
                    $display("FAIL random_%0d: op=%0d a=%h b=%h got hi=%h lo=%h div0=%b lat=%0d, required %h %h %b %0d",
                             i, o, a, b, rh, rl, rd, lat, eh, el, ed, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_abort();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
